// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The revoked strobe exists only when HOLD_LIMIT_EN is defined.
interface rr_decoder_arbiter_if;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] gnt;
    logic       busy;
`ifdef HOLD_LIMIT_EN
    logic       revoked;
`endif

    modport master (
        output req,
        input  gnt_idx,
        input  gnt_valid,
        input  gnt,
`ifdef HOLD_LIMIT_EN
        input  revoked,
`endif
        input  busy
    );

    modport slave (
        input  req,
        output gnt_idx,
        output gnt_valid,
        output gnt,
`ifdef HOLD_LIMIT_EN
        output revoked,
`endif
        output busy
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter driving a 2-to-4 decoder select.
// Optional HOLD_LIMIT_EN revokes grants held for MAX_HOLD cycles.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input logic clk,
    input logic rst_n,
    rr_decoder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, GRANT, RELEASE
    } state_t;

    localparam bit CFG_OK = (MAX_HOLD >= 2) && (MAX_HOLD <= 255)
                         && ((1 << CNT_W) > MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic [3:0] gnt_q;
    logic [1:0] win;
    logic       found;
    logic       own_req;
    logic       force_rel;

`ifdef HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rev_q, rev_d;
    assign force_rel = (cnt_q == CNT_W'(MAX_HOLD));
`else
    assign force_rel = 1'b0;
`endif

    assign own_req = bus.req[idx_q];

    // First set request at or after ptr, wrapping mod 4.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && bus.req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef HOLD_LIMIT_EN
        cnt_d   = cnt_q;
        rev_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    idx_d   = win;
                    vld_d   = 1'b1;
                    ptr_d   = win + 2'd1;
`ifdef HOLD_LIMIT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end
            end
            GRANT: begin
                if (!own_req || force_rel) begin
                    state_d = RELEASE;
                    vld_d   = 1'b0;
`ifdef HOLD_LIMIT_EN
                    rev_d   = own_req;
`endif
                end
`ifdef HOLD_LIMIT_EN
                else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            gnt_q   <= vld_d ? (4'b0001 << idx_d) : 4'b0000;
        end
    end

`ifdef HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rev_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rev_q <= rev_d;
        end
    end

    assign bus.revoked = rev_q;
`endif

    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = vld_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);

    a_cfg: assert property (@(posedge clk) CFG_OK);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.gnt));

    a_match: assert property (@(posedge clk) disable iff (!rst_n)
        bus.gnt_valid |-> bus.gnt[bus.gnt_idx]);

    // Back-to-back valid cycles must belong to the same grant.
    a_gap: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.gnt_valid && $past(bus.gnt_valid))
        |-> (state_q == GRANT && bus.gnt_idx == $past(bus.gnt_idx)));
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with an owner-level model
// compared every cycle on the falling clock edge.
module tb_rr_decoder_arbiter;
    localparam int MAXH = 4;
`ifdef HOLD_LIMIT_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    rr_decoder_arbiter_if bus();

    rr_decoder_arbiter #(
        .MAX_HOLD(MAXH),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, whether a dead cycle is pending,
    // and where the next search starts.
    int m_owner = -1;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_dead  = 1'b0;
    bit m_rev   = 1'b0;
    int win;
    bit got;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_idx   = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_dead  = 1'b0;
            m_rev   = 1'b0;
        end else begin
            m_rev = 1'b0;
            if (m_dead) begin
                m_dead = 1'b0;
            end else if (m_owner < 0) begin
                got = 1'b0;
                win = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!got && bus.req[(m_ptr + i) % 4]) begin
                        got = 1'b1;
                        win = (m_ptr + i) % 4;
                    end
                end
                if (got) begin
                    m_owner = win;
                    m_idx   = win;
                    m_ptr   = (win + 1) % 4;
                    m_hold  = 1;
                end
            end else if (!bus.req[m_owner]) begin
                m_owner = -1;
                m_dead  = 1'b1;
            end else if (HOLD && m_hold == MAXH) begin
                m_owner = -1;
                m_dead  = 1'b1;
                m_rev   = 1'b1;
            end else begin
                m_hold++;
            end
        end
    end

    logic [3:0] e_gnt;
    logic       e_vld;
    logic       e_busy;
    logic       bad;

    always @(negedge clk) begin
        e_vld  = (m_owner >= 0);
        e_gnt  = e_vld ? (4'b0001 << m_idx) : 4'b0000;
        e_busy = e_vld || m_dead;
        bad = (bus.gnt_valid !== e_vld)
           || (bus.gnt_idx !== 2'(m_idx))
           || (bus.gnt !== e_gnt)
           || (bus.busy !== e_busy);
`ifdef HOLD_LIMIT_EN
        bad = bad || (bus.revoked !== m_rev);
`endif
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t vld %b/%b idx %0d/%0d gnt %b/%b busy %b/%b",
                     $time, bus.gnt_valid, e_vld, bus.gnt_idx, m_idx,
                     bus.gnt, e_gnt, bus.busy, e_busy);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gnt_valid && n < 20);
        check(nm, int'(bus.gnt_valid), 1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 20);
        check(nm, int'(bus.busy), 0);
    endtask

    int nv, n, held, cur, revs, nbad;
    bit prev;
    int order[$];
    int lens[$];
    int exp2[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req = 4'b0000;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_vld", int'(bus.gnt_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_idx", int'(bus.gnt_idx), 0);
        #2 rst_n = 1'b1;

        // 1: single requester, 5-cycle hold
        @(negedge clk);
        bus.req = 4'b0001;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_lat", int'(bus.gnt), 1);
            if (i == 5) check("t1_rel_busy", int'(bus.busy), 1);
            if (i == 6) check("t1_idle_busy", int'(bus.busy), 0);
            if (bus.gnt_valid) nv++;
            if (nv == 5) bus.req = 4'b0000;
        end
        check("t1_len", nv, 5);
        check("t1_ptr", m_ptr, 1);

        // 2: all request, owners drop after 2 grant cycles
        do_reset();
        bus.req = 4'hf;
        held = 0;
        prev = 1'b0;
        order.delete();
        for (int i = 0; i < 80 && order.size() < 5; i++) begin
            @(negedge clk);
            if (bus.gnt_valid && !prev) order.push_back(int'(bus.gnt_idx));
            prev = bus.gnt_valid;
            held = bus.gnt_valid ? held + 1 : 0;
            bus.req = (held >= 2) ? (4'hf & ~(4'b0001 << bus.gnt_idx)) : 4'hf;
        end
        bus.req = 4'b0000;
        check("t2_count", order.size(), 5);
        for (int k = 0; k < 5; k++) check("t2_order", order[k], exp2[k]);
        wait_idle("t2_idle");

        // 3: pointer wrap from 3 back to 0
        do_reset();
        bus.req = 4'b0100;
        wait_grant("t3_g2", n);
        check("t3_gnt2", int'(bus.gnt), 4);
        bus.req = 4'b0000;
        wait_idle("t3_idle");
        bus.req = 4'b1001;
        wait_grant("t3_g3", n);
        check("t3_gnt3", int'(bus.gnt), 8);
        bus.req = 4'b0001;
        wait_grant("t3_g0", n);
        check("t3_gnt0", int'(bus.gnt), 1);
        check("t3_gap", n, 3);
        check("t3_ptr", m_ptr, 1);
        bus.req = 4'b0000;
        wait_idle("t3_idle2");

        // 4: asynchronous reset mid-grant
        do_reset();
        bus.req = 4'b0110;
        wait_grant("t4_g1", n);
        check("t4_gnt1", int'(bus.gnt), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_gnt", int'(bus.gnt), 0);
        check("t4_async_vld", int'(bus.gnt_valid), 0);
        check("t4_async_busy", int'(bus.busy), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t4_regrant", int'(bus.gnt), 2);
        bus.req = 4'b0000;
        wait_idle("t4_idle");

`ifdef HOLD_LIMIT_EN
        // 5: timeout alternation between 0 and 1
        do_reset();
        bus.req = 4'b0011;
        order.delete();
        lens.delete();
        cur = 0;
        revs = 0;
        prev = 1'b0;
        for (int i = 0; i < 80 && order.size() < 4; i++) begin
            @(negedge clk);
            if (bus.revoked) revs++;
            if (bus.gnt_valid && !prev) begin
                order.push_back(int'(bus.gnt_idx));
                cur = 0;
            end
            if (bus.gnt_valid) cur++;
            if (!bus.gnt_valid && prev) lens.push_back(cur);
            prev = bus.gnt_valid;
        end
        check("t5_count", order.size(), 4);
        for (int k = 0; k < 4; k++) check("t5_order", order[k], k % 2);
        check("t5_nlen", lens.size(), 3);
        for (int k = 0; k < 3; k++) check("t5_len", lens[k], 4);
        check("t5_revs", revs, 3);
        bus.req = 4'b0000;
        wait_idle("t5_idle");
`else
        // 6: grant held indefinitely without the limit
        do_reset();
        bus.req = 4'b0001;
        wait_grant("t6_g0", n);
        nbad = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0001 || !bus.busy || !bus.gnt_valid) nbad++;
        end
        check("t6_hold", nbad, 0);
        bus.req = 4'b0000;
        wait_idle("t6_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
